// File: rtl/nsa_pkg.sv
// nsa_pkg: shared definitions for nibble_serial_adder_ctrl.
//   - nsa_state_e   : controller states (IDLE, ADD, HOLD)
//   - nsa_cnt_w()   : width of the nibble-pass counter for a given pass count
//   - nsa_width_ok(): operand-width legality (multiple of 4, 4..32)
package nsa_pkg;

    localparam int NSA_WIDTH_MIN = 4;
    localparam int NSA_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } nsa_state_e;

    // A one-pass build still needs a 1-bit counter so the port widths stay legal.
    function automatic int nsa_cnt_w(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

    function automatic bit nsa_width_ok(input int w);
        return (w % 4 == 0) && (w >= NSA_WIDTH_MIN) && (w <= NSA_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// add4_slice: gate-level 4-bit carry-lookahead adder.
//   A[3:0], B[3:0], C0 : operands and carry-in
//   S[3:0], C4         : sum and carry-out
// Every carry is a flat sum-of-products of generate/propagate terms, so no
// carry ripples through the slice.
module add4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] S,
    output logic       C4
);
    logic [3:0] p, g;
    logic       c1, c2, c3;

    assign p = A ^ B;
    assign g = A & B;

    assign c1 = g[0] | (p[0] & C0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & C0);
    assign C4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & C0);

    assign S = p ^ {c3, c2, c1, C0};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: round-robin arbiter + sequencer that runs a
// WIDTH-bit add through one shared 4-bit CLA slice, one nibble per cycle,
// LSB first, with the carry held in a register between passes.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/ready         : request handshake (ready only in IDLE)
//   reqN_a, reqN_b, reqN_cin : operands and carry-in
//   reqN_sub                 : subtract (only when NSA_SUB_EN is defined)
//   res_valid/ready          : result handshake, result held in HOLD
//   res_sum/cout/ovf/id      : sum, carry-out, signed overflow, owner
//   busy                     : high outside IDLE
// Optional feature macro: NSA_SUB_EN (adds reqN_sub and subtraction).
module nibble_serial_adder_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
`ifdef NSA_SUB_EN
    input  logic             req0_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
`ifdef NSA_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_id,
    output logic             busy
);
    localparam int  NIB      = WIDTH / 4;
    localparam int  CW       = nsa_cnt_w(NIB);
    localparam bit  WIDTH_OK = nsa_width_ok(WIDTH);

    if (!WIDTH_OK) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 in 4..32");
    end

    nsa_state_e       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             cout_r, ovf_r, id_r, last_grant;
    logic             grant0, grant1;
    logic             sub0, sub1, sel_sub;
    logic [3:0]       s_nib;
    logic             c4;
    logic [WIDTH-1:0] sum_next;

`ifdef NSA_SUB_EN
    assign sub0 = req0_sub;
    assign sub1 = req1_sub;
`else
    assign sub0 = 1'b0;
    assign sub1 = 1'b0;
`endif

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_grant);
            grant1 = req1_valid && (!req0_valid || !last_grant);
        end
    end

    assign sel_sub    = grant1 ? sub1 : sub0;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    add4_slice u_slice (
        .A  (a_r[cnt*4 +: 4]),
        .B  (b_r[cnt*4 +: 4]),
        .C0 (carry),
        .S  (s_nib),
        .C4 (c4)
    );

    // New nibble enters at the top; after NIB passes nibble 0 sits at the bottom.
    if (NIB == 1) begin : g_one_pass
        assign sum_next = s_nib;
    end else begin : g_multi_pass
        assign sum_next = {s_nib, sum_r[WIDTH-1:4]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            ovf_r      <= 1'b0;
            id_r       <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_r        <= grant1 ? req1_a : req0_a;
                        // b is stored already inverted for subtract so the
                        // overflow check sees the effective operand.
                        b_r        <= sel_sub ? ~(grant1 ? req1_b : req0_b)
                                              :  (grant1 ? req1_b : req0_b);
                        carry      <= sel_sub ? 1'b1 : (grant1 ? req1_cin : req0_cin);
                        cnt        <= '0;
                        id_r       <= grant1;
                        last_grant <= grant1;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    carry <= c4;
                    sum_r <= sum_next;
                    if (cnt == CW'(NIB - 1)) begin
                        cnt    <= '0;
                        cout_r <= c4;
                        ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (s_nib[3] != a_r[WIDTH-1]);
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_valid = (state == HOLD);
    assign res_sum   = sum_r;
    assign res_cout  = cout_r;
    assign res_ovf   = ovf_r;
    assign res_id    = id_r;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_cin = 1'b0, req1_cin = 1'b0;
`ifdef NSA_SUB_EN
    logic         req0_sub = 1'b0, req1_sub = 1'b0;
`endif
    logic         res_valid, res_ready = 1'b1;
    logic [W-1:0] res_sum;
    logic         res_cout, res_ovf, res_id, busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic exp_last = 1'b1;
    exp_t q[$];

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
`ifdef NSA_SUB_EN
        .req0_sub(req0_sub),
`endif
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
`ifdef NSA_SUB_EN
        .req1_sub(req1_sub),
`endif
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arithmetic: full-width add of a, effective b and carry-in.
    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   f;
        be     = sub ? ~b : b;
        f      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = f[W-1:0];
        e.cout = f[W];
        e.ovf  = (a[W-1] == be[W-1]) && (f[W-1] != a[W-1]);
        e.id   = id;
        return e;
    endfunction

    // Scoreboard: every completed result handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL result_unexpected: got sum=%h cout=%b ovf=%b id=%b, none expected",
                         res_sum, res_cout, res_ovf, res_id);
            end else begin
                e = q.pop_front();
                if ({res_sum, res_cout, res_ovf, res_id} !== e) begin
                    errors++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b id=%b, want sum=%h cout=%b ovf=%b id=%b",
                             res_sum, res_cout, res_ovf, res_id, e.sum, e.cout, e.ovf, e.id);
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
`ifdef NSA_SUB_EN
            req1_sub = sub;
`endif
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
`ifdef NSA_SUB_EN
            req0_sub = sub;
`endif
        end
        if (sub && 0) $display("unreachable");
    endtask

    // Raise one request, wait for its accept, optionally push the model result.
    task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input bit push, output int acc);
        @(posedge clk); #1;
        set_req(id, 1'b1, a, b, cin, sub);
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept_timeout: req%0d never got ready, want ready within 40 cycles", id);
        end else begin
            if (push) q.push_back(model(id, a, b, cin, sub));
            exp_last = id;
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results still pending, want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_sum, res_cout, res_ovf, res_id, busy, req0_ready, req1_ready} !== '0) begin
                errors++;
                $display("FAIL reset_state: got valid=%b sum=%h cout=%b ovf=%b id=%b busy=%b rdy=%b%b, want all 0",
                         res_valid, res_sum, res_cout, res_ovf, res_id, busy, req1_ready, req0_ready);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0;
        exp_last = 1'b1;
    endtask

    task automatic test_single_add();
        int acc, seen;
        res_ready = 1'b1;
        send(1'b0, 16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0, acc);
        q.push_back('{sum: 16'h2201, cout: 1'b0, ovf: 1'b0, id: 1'b0});
        seen = -1;
        for (int i = 0; i < 20 && seen < 0; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen = cyc;
        end
        checks++;
        if (seen != acc + NIB + 1) begin
            errors++;
            $display("FAIL single_latency: res_valid at +%0d cycles, want +%0d", seen - acc, NIB + 1);
        end
        wait_drain();
    endtask

    task automatic test_carry_ovf();
        int acc;
        send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, acc);
        q.push_back('{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, id: 1'b0});
        wait_drain();
        send(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, acc);
        q.push_back('{sum: 16'h8000, cout: 1'b0, ovf: 1'b1, id: 1'b0});
        wait_drain();
        send(1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1, acc);
        wait_drain();
    endtask

    // Holds the chosen valids high and checks who wins each accept.
    task automatic run_grants(input logic v0, input logic v1, input int n, input bit chk_period);
        int   got, prev;
        logic g, want;
        got = 0; prev = -1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        set_req(1'b0, v0, W'($urandom), W'($urandom), 1'b0, 1'b0);
        set_req(1'b1, v1, W'($urandom), W'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < n * 20 && got < n; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                want = (v0 && v1) ? !exp_last : v1;
                g    = req1_ready;
                checks++;
                if ({req1_ready, req0_ready} !== (want ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL arb_grant: got ready=%b%b, want req%0d", req1_ready, req0_ready, want);
                end
                if (chk_period && prev >= 0) begin
                    checks++;
                    if (cyc - prev != NIB + 2) begin
                        errors++;
                        $display("FAIL b2b_period: got %0d cycles, want %0d", cyc - prev, NIB + 2);
                    end
                end
                if (g) q.push_back(model(1'b1, req1_a, req1_b, req1_cin, 1'b0));
                else   q.push_back(model(1'b0, req0_a, req0_b, req0_cin, 1'b0));
                exp_last = g;
                prev     = cyc;
                got++;
                @(posedge clk); #1;
                if (g) set_req(1'b1, v1, W'($urandom), W'($urandom), 1'b1, 1'b0);
                else   set_req(1'b0, v0, W'($urandom), W'($urandom), 1'b0, 1'b0);
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL arb_count: got %0d grants, want %0d", got, n);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_arb_alternate();
        run_grants(1'b1, 1'b1, 6, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_grants(1'b0, 1'b1, 3, 1'b1);
    endtask

    task automatic test_backpressure();
        int acc;
        logic [W+4:0] snap;
        res_ready = 1'b0;
        send(1'b0, 16'h4321, 16'h1111, 1'b1, 1'b0, 1'b1, acc);
        for (int i = 0; i < 20 && res_valid !== 1'b1; i++) @(negedge clk);
        snap = {res_valid, res_sum, res_cout, res_ovf, res_id, busy};
        @(posedge clk); #1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_sum, res_cout, res_ovf, res_id, busy} !== snap || snap[W+4] !== 1'b1
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b sum=%h rdy=%b%b, want valid=1 sum=%h rdy=00",
                         res_valid, res_sum, req1_ready, req0_ready, snap[W+3:4]);
            end
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid_op();
        int acc;
        bit rose;
        res_ready = 1'b1;
        send(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got busy=%b valid=%b, want 0 0", busy, res_valid);
        end
        rose = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose) begin
            errors++;
            $display("FAIL rst_mid_discard: got res_valid=1 after reset, want 0");
        end
    endtask

`ifdef NSA_SUB_EN
    task automatic test_sub();
        int acc;
        send(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, acc);
        q.push_back('{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0, id: 1'b1});
        wait_drain();
        send(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, acc);
        q.push_back('{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1, id: 1'b1});
        wait_drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_carry_ovf();
        test_arb_alternate();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
`ifdef NSA_SUB_EN
        test_sub();
`endif
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d results never produced, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
